// File: rtl/phase_cal_ctrl_pkg.sv
// Shared types and constants for the ADC phase calibration controller.
// Optional manual delay override is enabled by PHASE_CAL_MANUAL_EN.
package phase_cal_ctrl_pkg;

    localparam int unsigned NUM_TAPS = 8;
    localparam int unsigned DELAY_W  = 3;

    typedef logic [DELAY_W-1:0] tap_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_PICK,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/phase_window_pick.sv
// Combinational eye-window picker: centre of the longest run of passing taps,
// no wrap-around, ties resolved to the lowest start tap.
module phase_window_pick
    import phase_cal_ctrl_pkg::*;
(
    input  logic [NUM_TAPS-1:0] i_window_mask,
    output tap_t                o_best_tap,
    output logic                o_valid
);

    logic [3:0] w_run_len;
    logic [3:0] w_run_start;
    logic [3:0] w_best_len;
    logic [3:0] w_best_start;
    logic [3:0] w_centre;

    always_comb begin
        w_run_len    = '0;
        w_run_start  = '0;
        w_best_len   = '0;
        w_best_start = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            if (i_window_mask[i]) begin
                if (w_run_len == 4'd0) begin
                    w_run_start = 4'(i);
                end
                w_run_len = w_run_len + 4'd1;
                // Strictly greater keeps the earliest run on a tie
                if (w_run_len > w_best_len) begin
                    w_best_len   = w_run_len;
                    w_best_start = w_run_start;
                end
            end else begin
                w_run_len = '0;
            end
        end
        w_centre   = w_best_start + ((w_best_len - 4'd1) >> 1);
        o_valid    = (w_best_len != 4'd0);
        o_best_tap = o_valid ? tap_t'(w_centre) : '0;
    end

endmodule

// File: rtl/phase_cal_ctrl.sv
// Sweeps the ADC capture delay taps, scores each against the training pattern
// and parks on the centre of the widest eye. Manual override: PHASE_CAL_MANUAL_EN.
module phase_cal_ctrl
    import phase_cal_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned SAMPLES_PER_TAP = 64
) (
    input  logic                in_clk_p,
    input  logic                reset,
    input  logic                start,
    input  logic                sample_valid,
    input  logic                sample_match,
`ifdef PHASE_CAL_MANUAL_EN
    input  logic                manual_en,
    input  logic [DELAY_W-1:0]  manual_delay,
`endif
    output logic [DELAY_W-1:0]  delay,
    output logic                delay_update,
    output logic                busy,
    output logic                done,
    output logic                cal_fail,
    output logic [NUM_TAPS-1:0] window_mask
);

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
    localparam logic [9:0] SAMPLE_LAST = 10'(SAMPLES_PER_TAP - 1);
    localparam tap_t       TAP_LAST    = tap_t'(NUM_TAPS - 1);

    state_t              r_state;
    state_t              w_state_next;
    tap_t                r_tap;
    logic [9:0]          r_cnt;
    logic                r_tap_pass;
    tap_t                r_delay;
    logic                r_cal_fail;
    logic [NUM_TAPS-1:0] r_mask;

    tap_t                w_delay_next;
    tap_t                w_best_tap;
    logic                w_best_valid;
    logic                w_manual;
    logic                w_start_ok;
    logic                w_mismatch;
    logic                w_last_sample;
    logic                w_last_settle;

`ifdef PHASE_CAL_MANUAL_EN
    assign w_manual = manual_en;
`else
    assign w_manual = 1'b0;
`endif

    assign w_start_ok    = start && !w_manual;
    assign w_mismatch    = sample_valid && !sample_match;
    assign w_last_sample = sample_valid && sample_match && (r_cnt == SAMPLE_LAST);
    assign w_last_settle = (r_cnt == SETTLE_LAST);

    phase_window_pick u_pick (
        .i_window_mask (r_mask),
        .o_best_tap    (w_best_tap),
        .o_valid       (w_best_valid)
    );

    always_ff @(posedge in_clk_p) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_state_next = ST_APPLY;
            ST_APPLY:   w_state_next = ST_SETTLE;
            ST_SETTLE:  if (w_last_settle) w_state_next = ST_MEASURE;
            ST_MEASURE: if (w_mismatch || w_last_sample) w_state_next = ST_NEXT;
            ST_NEXT:    w_state_next = (r_tap == TAP_LAST) ? ST_PICK : ST_APPLY;
            ST_PICK:    w_state_next = ST_FINISH;
            ST_FINISH:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // APPLY always pulses delay_update; elsewhere it flags an actual change
    always_comb begin
        w_delay_next = r_delay;
        case (r_state)
            ST_APPLY: w_delay_next = r_tap;
            ST_PICK:  w_delay_next = w_best_valid ? w_best_tap : '0;
`ifdef PHASE_CAL_MANUAL_EN
            ST_IDLE:  if (manual_en) w_delay_next = manual_delay;
`endif
            default:  w_delay_next = r_delay;
        endcase
        delay_update = !reset && ((r_state == ST_APPLY) || (w_delay_next != r_delay));
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_FINISH);
    end

    always_ff @(posedge in_clk_p) begin
        if (reset) begin
            r_tap      <= '0;
            r_cnt      <= '0;
            r_tap_pass <= 1'b0;
            r_delay    <= '0;
            r_cal_fail <= 1'b0;
            r_mask     <= '0;
        end else begin
            r_delay <= w_delay_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_tap      <= '0;
                        r_cnt      <= '0;
                        r_mask     <= '0;
                        r_cal_fail <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    r_cnt      <= '0;
                    r_tap_pass <= 1'b0;
                end
                ST_SETTLE: begin
                    r_cnt <= w_last_settle ? '0 : r_cnt + 10'd1;
                end
                ST_MEASURE: begin
                    if (w_mismatch) begin
                        r_tap_pass <= 1'b0;
                        r_cnt      <= '0;
                    end else if (w_last_sample) begin
                        r_tap_pass <= 1'b1;
                        r_cnt      <= '0;
                    end else if (sample_valid) begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_NEXT: begin
                    r_mask[r_tap] <= r_tap_pass;
                    r_tap         <= r_tap + tap_t'(1);
                end
                ST_PICK: begin
                    r_cal_fail <= !w_best_valid;
                end
                default: begin
                end
            endcase
        end
    end

    assign delay       = r_delay;
    assign cal_fail    = r_cal_fail;
    assign window_mask = r_mask;

endmodule

// File: tb/tb_phase_cal_ctrl.sv
// Self-checking bench for phase_cal_ctrl against a brute-force window model.
// Build with +define+PHASE_CAL_MANUAL_EN to also exercise the manual override.
module tb_phase_cal_ctrl;
    import phase_cal_ctrl_pkg::*;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned SPT    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sample_valid;
    logic       sample_match;
    logic [2:0] delay;
    logic       delay_update;
    logic       busy;
    logic       done;
    logic       cal_fail;
    logic [7:0] window_mask;
`ifdef PHASE_CAL_MANUAL_EN
    logic       manual_en;
    logic [2:0] manual_delay;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    phase_cal_ctrl #(
        .SETTLE_CYCLES   (SETTLE),
        .SAMPLES_PER_TAP (SPT)
    ) dut (
        .in_clk_p     (clk),
        .reset        (reset),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_match (sample_match),
`ifdef PHASE_CAL_MANUAL_EN
        .manual_en    (manual_en),
        .manual_delay (manual_delay),
`endif
        .delay        (delay),
        .delay_update (delay_update),
        .busy         (busy),
        .done         (done),
        .cal_fail     (cal_fail),
        .window_mask  (window_mask)
    );

    // Reference: exhaustive search over every [s,e] all-pass interval
    function automatic void ref_pick(input logic [7:0] m, output logic [2:0] d, output logic f);
        int best_len = 0;
        int best_s   = 0;
        for (int s = 0; s < 8; s++) begin
            for (int e = s; e < 8; e++) begin
                bit all_pass = 1'b1;
                for (int k = s; k <= e; k++) if (!m[k]) all_pass = 1'b0;
                if (all_pass && (e - s + 1) > best_len) begin
                    best_len = e - s + 1;
                    best_s   = s;
                end
            end
        end
        f = (best_len == 0);
        d = f ? 3'd0 : 3'(best_s + (best_len - 1) / 2);
    endfunction

    // Cycle (APPLY of tap 0 = 1) on which done is high, valid on odd cycles only
    function automatic int ref_done_cycle(input logic [7:0] m);
        int t = 0;
        for (int tap = 0; tap < 8; tap++) begin
            int cnt = 0;
            t += 1 + SETTLE;
            while (1) begin
                t++;
                if ((t % 2) == 1) begin
                    if (!m[tap]) break;
                    cnt++;
                    if (cnt == SPT) break;
                end
            end
            t += 1;
        end
        return t + 2;
    endfunction

    task automatic run_sweep(input logic [7:0] pass, input int vmode, input bit poke,
                             output int done_cyc, output int updates, output bit idle_after);
        int c;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        c = 1; updates = 0; seen = 1'b0; done_cyc = -1;
        do begin
            if (delay_update) updates++;
            if (done) begin
                seen = 1'b1;
                done_cyc = c;
            end
            sample_valid = (vmode == 0) ? ((c % 2) == 1) : (($urandom % 3) != 0);
            sample_match = pass[delay];
            start = (poke && (c == 20)) || seen;
            @(negedge clk);
            c++;
        end while (!seen && c < 4000);
        start = 1'b0;
        idle_after = !busy;
        @(negedge clk);
        idle_after = idle_after && !busy && !done;
        sample_valid = 1'b0;
    endtask

    task automatic test_pattern(input string name, input logic [7:0] pass, input int vmode, input bit poke);
        int done_cyc, updates;
        bit idle_after;
        logic [2:0] exp_d;
        logic exp_f;
        ref_pick(pass, exp_d, exp_f);
        run_sweep(pass, vmode, poke, done_cyc, updates, idle_after);
        tests++;
        if (window_mask !== pass) begin
            fails++; $display("FAIL %s window_mask: got %b expected %b", name, window_mask, pass);
        end
        tests++;
        if (delay !== exp_d) begin
            fails++; $display("FAIL %s delay: got %0d expected %0d", name, delay, exp_d);
        end
        tests++;
        if (cal_fail !== exp_f) begin
            fails++; $display("FAIL %s cal_fail: got %b expected %b", name, cal_fail, exp_f);
        end
        tests++;
        if (updates !== 8 + ((exp_d != 3'd7) ? 1 : 0)) begin
            fails++; $display("FAIL %s delay_update count: got %0d expected %0d", name, updates,
                              8 + ((exp_d != 3'd7) ? 1 : 0));
        end
        tests++;
        if (!idle_after) begin
            fails++; $display("FAIL %s busy after done: got busy=%b expected 0", name, busy);
        end
        tests++;
        if (vmode == 0) begin
            if (done_cyc !== ref_done_cycle(pass)) begin
                fails++; $display("FAIL %s done cycle: got %0d expected %0d", name, done_cyc, ref_done_cycle(pass));
            end
        end else if (done_cyc < 0) begin
            fails++; $display("FAIL %s done timeout: got %0d expected a done pulse", name, done_cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({delay, delay_update, busy, done, cal_fail, window_mask} !== 15'd0) begin
            fails++; $display("FAIL reset outputs: got delay=%0d upd=%b busy=%b done=%b fail=%b mask=%b expected all 0",
                              delay, delay_update, busy, done, cal_fail, window_mask);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset idle: got busy=%b expected 0", busy);
        end
    endtask

`ifdef PHASE_CAL_MANUAL_EN
    task automatic test_manual;
        int pulses = 0;
        bit was_busy = 1'b0;
        manual_en = 1'b1;
        manual_delay = 3'd6;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (delay_update) pulses++;
            if (busy) was_busy = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (delay !== 3'd6) begin
            fails++; $display("FAIL manual delay: got %0d expected 6", delay);
        end
        tests++;
        if (pulses !== 1) begin
            fails++; $display("FAIL manual pulses: got %0d expected 1", pulses);
        end
        tests++;
        if (was_busy) begin
            fails++; $display("FAIL manual start ignored: got busy=1 expected 0");
        end
        manual_en = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_sweep;
        int c;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Tap 4 measures on cycles 52..59 with odd-cycle valids
        for (c = 1; c < 54; c++) begin
            sample_valid = ((c % 2) == 1);
            sample_match = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (delay !== 3'd4 || window_mask !== 8'h0F) begin
            fails++; $display("FAIL midsweep precondition: got delay=%0d mask=%b expected 4 00001111", delay, window_mask);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({delay, delay_update, busy, done, cal_fail, window_mask} !== 15'd0) begin
            fails++; $display("FAIL midsweep reset: got delay=%0d upd=%b busy=%b done=%b fail=%b mask=%b expected all 0",
                              delay, delay_update, busy, done, cal_fail, window_mask);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL midsweep no resume: got busy=%b expected 0", busy);
        end
        sample_valid = 1'b0;
        test_pattern("after_reset", 8'b0111_1110, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            test_pattern("random", 8'($urandom), 1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sample_valid = 1'b0;
        sample_match = 1'b0;
`ifdef PHASE_CAL_MANUAL_EN
        manual_en = 1'b0;
        manual_delay = 3'd0;
`endif
        test_reset();
`ifdef PHASE_CAL_MANUAL_EN
        test_manual();
`endif
        test_pattern("window_2_5", 8'b0011_1100, 0, 1'b0);
        test_pattern("all_fail", 8'b0000_0000, 0, 1'b0);
        test_pattern("tie", 8'b0011_0011, 0, 1'b0);
        test_pattern("all_pass_timing", 8'b1111_1111, 0, 1'b0);
        test_pattern("start_while_busy", 8'b1100_0000, 0, 1'b1);
        test_pattern("single_tap7", 8'b1000_0000, 0, 1'b0);
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_cal_ctrl.md
PHASE_CAL_CTRL -- requirements
Module: phase_cal_ctrl

Interface
REQ-001 SETTLE_CYCLES, default 16: idle cycles after each delay change before sampling; legal range 1..255.
REQ-002 SAMPLES_PER_TAP, default 64: valid samples compared per tap; legal range 1..1023.
REQ-003 in_clk_p  input  1  clock; all state on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to run a calibration sweep.
REQ-006 sample_valid  input  1  qualifies sample_match this cycle.
REQ-007 sample_match  input  1  1 = captured ADC word equals the training pattern.
REQ-008 delay  output  3  tap select driven to the phase-adjust block.
REQ-009 delay_update  output  1  one-cycle pulse whenever delay changes.
REQ-010 busy  output  1  high from sweep start until done.
REQ-011 done  output  1  one-cycle pulse at sweep end.
REQ-012 cal_fail  output  1  sticky; no tap passed in last sweep.
REQ-013 window_mask  output  8  bit i = tap i passed in last sweep.

Function
REQ-014 FSM states: IDLE, APPLY, SETTLE, MEASURE, NEXT, PICK, FINISH.
REQ-015 IDLE: start=1 clears tap index, window_mask and cal_fail, and enters APPLY next cycle; busy rises that same next cycle.
REQ-016 APPLY (1 cycle): delay <= tap index, delay_update=1 for exactly this cycle, then SETTLE.
REQ-017 SETTLE: exactly SETTLE_CYCLES cycles, sample inputs ignored, then MEASURE.
REQ-018 MEASURE: counts cycles with sample_valid=1; tap passes iff SAMPLES_PER_TAP valid samples all have sample_match=1.
REQ-019 First valid mismatch fails the tap immediately and goes to NEXT the following cycle, without waiting for the remaining samples.
REQ-020 Cycles with sample_valid=0 do not advance the sample count; there is no timeout.
REQ-021 NEXT (1 cycle): records pass/fail in window_mask[tap]; tap<7 -> tap+1, APPLY; tap=7 -> PICK.
REQ-022 PICK (1 cycle): select the longest contiguous run of passing taps, with no wrap from 7 to 0; ties go to the lowest start tap.
REQ-023 The chosen tap is start + floor((len-1)/2); delay is set to it, with delay_update pulsed when the value changes.
REQ-024 No passing tap: cal_fail=1, delay=0, with delay_update pulsed if the value changes.
REQ-025 FINISH (1 cycle): done=1, busy drops the next cycle, return to IDLE; outputs hold.
REQ-026 start while busy is ignored; start in the FINISH cycle is ignored.
REQ-027 delay changes only in APPLY or PICK and is otherwise stable.

Reset
REQ-028 reset forces IDLE, delay=0, delay_update=0, busy=0, done=0, cal_fail=0, window_mask=0, and clears all counters.
REQ-029 reset takes priority over every event, including start and mid-sweep operation; a sweep aborted by reset does not resume.

Configuration
REQ-030 The optional feature is controlled by macro PHASE_CAL_MANUAL_EN.
REQ-031 Defined: adds inputs manual_en (1) and manual_delay (3). While manual_en=1 in IDLE, delay follows manual_delay with delay_update pulsed on change, and start is ignored.
REQ-032 Not defined: those ports do not exist and delay changes only by sweep.

Structure
REQ-033 A shared package holds the FSM state enum, the tap count constant (8) and the delay width (3).
REQ-034 Window selection is the sub-module phase_window_pick: combinational, window_mask in -> best tap + valid out.

Verification
REQ-035 Taps 2..5 pass, others mismatch -> window_mask=8'b0011_1100, delay=3, done pulse, cal_fail=0.
REQ-036 All taps fail -> window_mask=0, cal_fail=1, delay=0.
REQ-037 Taps 0,1 and 4,5 pass (tie) -> delay=0.
REQ-038 sample_valid duty 50%, all match, SAMPLES_PER_TAP=4, SETTLE_CYCLES=2 -> each tap takes 1+2+8+1 cycles; done at the expected cycle; delay_update count = 8 plus 1 if PICK changes delay.
REQ-039 reset asserted during the tap-4 MEASURE -> next cycle IDLE, all outputs at reset values; a new start then runs a full sweep.
REQ-040 With PHASE_CAL_MANUAL_EN: manual_en=1, manual_delay=6 -> delay=6 with one delay_update pulse; start ignored.
